// File: rtl/sync_counter_n_if.sv
// Control/status bundle for sync_counter_n.
// The master drives the start/stop, load and direction controls; the counter (slave) returns count and status.
interface sync_counter_n_if #(
    parameter int WIDTH = 8
);
    logic             s_s;
    logic             l;
    logic             up;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] c;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output s_s, l, up, d,
        input  c, tc, busy, done
    );

    modport slave (
        input  s_s, l, up, d,
        output c, tc, busy, done
    );
endinterface

// File: rtl/sync_counter_n.sv
// Parametrised up/down counter with a programmable modulus, a start/stop FSM,
// a registered terminal-count pulse and an optional one-shot stop at terminal.
//
// state | meaning
// IDLE  | not counting, c holds
// RUN   | counted on the last edge
// DONE  | one-shot reached terminal; holds until load or clr
module sync_counter_n #(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter int          ONE_SHOT = 0
) (
    input  logic                 clk,
    input  logic                 clr,
    sync_counter_n_if.slave      bus
);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             tc_q, tc_d;
    logic             at_term;
    logic [WIDTH-1:0] count_val;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        tc_d      = 1'b0;
        at_term   = bus.up ? (c_q == MAX_C) : (c_q == '0);
        load_val  = (bus.d > MAX_C) ? MAX_C : bus.d;
        // Wrap within 0..MAX_VAL rather than relying on 2**WIDTH rollover.
        if (bus.up) begin
            count_val = at_term ? '0 : c_q + WIDTH'(1);
        end else begin
            count_val = at_term ? MAX_C : c_q - WIDTH'(1);
        end

        if (bus.l) begin
            c_d     = load_val;
            state_d = bus.s_s ? ST_RUN : ST_IDLE;
        end else if (state_q != ST_DONE) begin
            if (bus.s_s) begin
                state_d = ST_RUN;
                if (at_term) begin
                    tc_d = 1'b1;
                    if (ONE_SHOT != 0) begin
                        state_d = ST_DONE;
                    end else begin
                        c_d = count_val;
                    end
                end else begin
                    c_d = count_val;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.c    = c_q;
    assign bus.tc   = tc_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (ONE_SHOT != 0) && (state_q == ST_DONE);
endmodule
